mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the core's three memory request streams (I-cache line read, D-cache line read, D-cache word write) onto the single external memory port. Sits directly downstream of `mips_core`, between its cache memory interfaces and main memory. One transaction is outstanding at a time. Fixed priority is used, with an aging override so instruction fetch cannot starve.

## Interface
Parameters:
- `ADDR_WIDTH`, default 26: byte-address width.
- `DATA_WIDTH`, default 32: word width.
- `LINE_WORDS`, default 4: beats per read burst (power of 2, ≥2).
- `STARVE_LIMIT`, default 16: cycles an I-cache request may wait before it is force-granted.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset; one clock, asynchronous, active-low.
- `ic_rd_req` in 1: I-cache read request, held until ack.
- `ic_rd_addr` in ADDR_WIDTH: I-cache read byte address.
- `ic_rd_valid` out 1: I-cache read data beat valid.
- `ic_rd_data` out DATA_WIDTH: I-cache read data beat.
- `ic_rd_ack` out 1: one-cycle pulse, I-cache burst complete.
- `dc_rd_req` in 1: D-cache read request, held until ack.
- `dc_rd_addr` in ADDR_WIDTH: D-cache read byte address.
- `dc_rd_valid` out 1: D-cache read data beat valid.
- `dc_rd_data` out DATA_WIDTH: D-cache read data beat.
- `dc_rd_ack` out 1: one-cycle pulse, D-cache burst complete.
- `dc_wr_req` in 1: D-cache write request, held until ack.
- `dc_wr_addr` in ADDR_WIDTH: D-cache write byte address (word-aligned).
- `dc_wr_data` in DATA_WIDTH: D-cache write data.
- `dc_wr_ack` out 1: one-cycle pulse, write accepted by memory.
- `mem_cmd_valid` out 1: command valid.
- `mem_cmd_ready` in 1: memory accepts command.
- `mem_cmd_write` out 1: 1 = write, 0 = read burst.
- `mem_cmd_addr` out ADDR_WIDTH: command address.
- `mem_wr_data` out DATA_WIDTH: write data, valid with command.
- `mem_rd_valid` in 1: read beat valid.
- `mem_rd_data` in DATA_WIDTH: read beat.
- `busy` out 1: state ≠ IDLE.

## Operation
- **States:** IDLE, CMD, RDATA, DONE.
- **IDLE grant order:** if `ic_wait == STARVE_LIMIT` and `ic_rd_req` is high, grant IC. Otherwise grant `dc_wr` > `dc_rd` > `ic_rd`.
  - The grant registers the owner, `mem_cmd_addr`, `mem_cmd_write` and `mem_wr_data`, then moves to CMD.
  - If no request is pending, stay in IDLE.
- **Read address alignment:** the low `$clog2(LINE_WORDS)+2` bits are forced to 0. Write addresses pass through unchanged.
- **CMD:** `mem_cmd_valid` = 1; all command fields are held stable until `mem_cmd_ready`.
  - On the handshake, a write goes to DONE.
  - On the handshake, a read clears the beat counter and goes to RDATA.
- **RDATA:** `mem_rd_data` is steered combinationally to the owner.
  - Owner `*_rd_valid` = `mem_rd_valid`. Non-owner `rd_valid` = 0.
  - The beat counter increments on each valid beat.
  - The beat with counter == `LINE_WORDS-1` moves to DONE.
- **DONE:** the owner's `*_ack` = 1 for exactly this cycle; the next state is IDLE.
  - The requester deasserts `req` in the cycle after ack, so IDLE never re-grants a completed request.
- **Aging counter `ic_wait`:** width `$clog2(STARVE_LIMIT+1)`.
  - Increments each cycle `ic_rd_req` is high and the I-cache is not being granted; saturates at `STARVE_LIMIT`.
  - Cleared on grant to the I-cache, or when `ic_rd_req` is low.
- **Stray inputs:** `mem_rd_valid` outside RDATA is ignored (no `rd_valid` to anyone, no state change). `mem_cmd_ready` outside CMD is ignored.
- **Reset, at any time including mid-burst:**
  - State → IDLE; `ic_wait` and the beat counter → 0.
  - Registered outputs (`mem_cmd_valid`, `mem_cmd_write`, `mem_cmd_addr`, `mem_wr_data`, all acks, `busy`) → 0.
  - The in-flight transaction is abandoned.

## Timing
- Request sampled in IDLE at cycle t → CMD with `mem_cmd_valid` = 1 at t+1.
- Write with `mem_cmd_ready` = 1 at t+1 → `dc_wr_ack` at t+2 → IDLE at t+3. Minimum write occupancy is 3 cycles.
- Read with ready at t+1 and beats at t+2 … t+1+LINE_WORDS → ack at t+2+LINE_WORDS.
- `*_rd_valid` and `*_rd_data` have zero latency from `mem_rd_*`; all other outputs are registered.
- Back-to-back: a new grant is possible in the IDLE cycle following DONE.

## Test plan
- **Single I-cache read:** `ic_rd_addr` = 0x0000123, ready = 1, beats 0xA0..0xA3 → at cycle 1: `mem_cmd_addr` = 0x0000120, write = 0; `ic_rd_valid` for 4 cycles with data 0xA0..0xA3; `ic_rd_ack` one cycle after the last beat; `dc_*_valid` stays 0.
- **All three requests at cycle 0** (each dropped after its ack) → command order is write (addr/data echoed), then D-cache read, then I-cache read; exactly one ack per requester.
- **Starvation,** `STARVE_LIMIT` = 16: `dc_rd_req` re-asserted continuously and `ic_rd_req` held → I-cache granted at the first IDLE after `ic_wait` reaches 16, ahead of the pending D-cache read.
- **Command backpressure:** `mem_cmd_ready` = 0 for 5 cycles on a write of 0xDEADBEEF to 0x0000040 → `mem_cmd_valid`, addr and data stable for all 5 cycles; `dc_wr_ack` only the cycle after ready rises.
- **Stray beat:** `mem_rd_valid` = 1 with 0x55 while IDLE → no `rd_valid` output, `busy` = 0, the next read still needs 4 beats.
- **Reset mid-burst:** assert `rst_n` = 0 after 2 of 4 beats → all outputs 0 immediately; after release, a new D-cache read completes with 4 fresh beats and a single `dc_rd_ack`.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-outstanding arbiter that places the I-cache line read,
// D-cache line read and D-cache word write streams onto one memory port.
// Fixed priority (write > D read > I read) with an aging override for I fetch.
module mem_arbiter #(
   parameter int ADDR_WIDTH   = 26,
   parameter int DATA_WIDTH   = 32,
   parameter int LINE_WORDS   = 4,
   parameter int STARVE_LIMIT = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ic_rd_req,
   input  logic [ADDR_WIDTH-1:0] ic_rd_addr,
   output logic                  ic_rd_valid,
   output logic [DATA_WIDTH-1:0] ic_rd_data,
   output logic                  ic_rd_ack,
   input  logic                  dc_rd_req,
   input  logic [ADDR_WIDTH-1:0] dc_rd_addr,
   output logic                  dc_rd_valid,
   output logic [DATA_WIDTH-1:0] dc_rd_data,
   output logic                  dc_rd_ack,
   input  logic                  dc_wr_req,
   input  logic [ADDR_WIDTH-1:0] dc_wr_addr,
   input  logic [DATA_WIDTH-1:0] dc_wr_data,
   output logic                  dc_wr_ack,
   output logic                  mem_cmd_valid,
   input  logic                  mem_cmd_ready,
   output logic                  mem_cmd_write,
   output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   input  logic                  mem_rd_valid,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  busy
);
   localparam int BEAT_W  = $clog2(LINE_WORDS);
   localparam int ALIGN_W = BEAT_W + 2;
   localparam int WAIT_W  = $clog2(STARVE_LIMIT + 1);
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << ALIGN_W) - 1);
   localparam logic [WAIT_W-1:0]     WAIT_MAX  = WAIT_W'(STARVE_LIMIT);
   localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {IDLE, CMD, RDATA, DONE} state_e;
   typedef enum logic [1:0] {OWN_IC, OWN_DR, OWN_DW} owner_e;

   state_e                  state_q, state_d;
   owner_e                  owner_q, owner_d;
   logic [BEAT_W-1:0]       beat_q, beat_d;
   logic [WAIT_W-1:0]       ic_wait_q, ic_wait_d;
   logic                    cmd_valid_q, cmd_valid_d;
   logic                    cmd_write_q, cmd_write_d;
   logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
   logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
   logic                    ic_ack_q, ic_ack_d;
   logic                    dr_ack_q, dr_ack_d;
   logic                    dw_ack_q, dw_ack_d;
   logic                    busy_q, busy_d;
   logic                    grant, ic_grant, finish, rd_phase;

   // Next-state: grant in IDLE, command handshake, beat counting, ack pulse.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      beat_d      = beat_q;
      cmd_valid_d = 1'b0;
      cmd_write_d = cmd_write_q;
      cmd_addr_d  = cmd_addr_q;
      wr_data_d   = wr_data_q;
      grant       = 1'b0;
      finish      = 1'b0;
      case (state_q)
         IDLE: begin
            grant = 1'b1;
            if (ic_rd_req && ic_wait_q == WAIT_MAX) owner_d = OWN_IC;
            else if (dc_wr_req)                     owner_d = OWN_DW;
            else if (dc_rd_req)                     owner_d = OWN_DR;
            else if (ic_rd_req)                     owner_d = OWN_IC;
            else                                    grant   = 1'b0;
            if (grant) begin
               state_d     = CMD;
               cmd_valid_d = 1'b1;
               cmd_write_d = (owner_d == OWN_DW);
               case (owner_d)
                  OWN_DW:  cmd_addr_d = dc_wr_addr;
                  OWN_DR:  cmd_addr_d = dc_rd_addr & LINE_MASK;
                  default: cmd_addr_d = ic_rd_addr & LINE_MASK;
               endcase
               wr_data_d = (owner_d == OWN_DW) ? dc_wr_data : '0;
            end
         end
         CMD: begin
            cmd_valid_d = 1'b1;
            if (mem_cmd_ready) begin
               cmd_valid_d = 1'b0;
               if (cmd_write_q) begin
                  state_d = DONE;
                  finish  = 1'b1;
               end else begin
                  beat_d  = '0;
                  state_d = RDATA;
               end
            end
         end
         RDATA: begin
            if (mem_rd_valid) begin
               beat_d = beat_q + 1'b1;
               if (beat_q == LAST_BEAT) begin
                  state_d = DONE;
                  finish  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      ic_grant = grant && (owner_d == OWN_IC);
      ic_ack_d = finish && (owner_q == OWN_IC);
      dr_ack_d = finish && (owner_q == OWN_DR);
      dw_ack_d = finish && (owner_q == OWN_DW);
      busy_d   = (state_d != IDLE);
   end

   // Aging: count cycles a pending I fetch is passed over, saturating.
   always_comb begin
      ic_wait_d = ic_wait_q;
      if (!ic_rd_req || ic_grant)    ic_wait_d = '0;
      else if (ic_wait_q != WAIT_MAX) ic_wait_d = ic_wait_q + 1'b1;
   end

   // State and registered outputs; reset abandons any in-flight transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IC;
         beat_q      <= '0;
         ic_wait_q   <= '0;
         cmd_valid_q <= 1'b0;
         cmd_write_q <= 1'b0;
         cmd_addr_q  <= '0;
         wr_data_q   <= '0;
         ic_ack_q    <= 1'b0;
         dr_ack_q    <= 1'b0;
         dw_ack_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         beat_q      <= beat_d;
         ic_wait_q   <= ic_wait_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_write_q <= cmd_write_d;
         cmd_addr_q  <= cmd_addr_d;
         wr_data_q   <= wr_data_d;
         ic_ack_q    <= ic_ack_d;
         dr_ack_q    <= dr_ack_d;
         dw_ack_q    <= dw_ack_d;
         busy_q      <= busy_d;
      end
   end

   // Read beats go straight through to the owner with no added latency.
   assign rd_phase    = (state_q == RDATA);
   assign ic_rd_valid = rd_phase && (owner_q == OWN_IC) && mem_rd_valid;
   assign dc_rd_valid = rd_phase && (owner_q == OWN_DR) && mem_rd_valid;
   assign ic_rd_data  = (rd_phase && owner_q == OWN_IC) ? mem_rd_data : '0;
   assign dc_rd_data  = (rd_phase && owner_q == OWN_DR) ? mem_rd_data : '0;

   assign mem_cmd_valid = cmd_valid_q;
   assign mem_cmd_write = cmd_write_q;
   assign mem_cmd_addr  = cmd_addr_q;
   assign mem_wr_data   = wr_data_q;
   assign ic_rd_ack     = ic_ack_q;
   assign dc_rd_ack     = dr_ack_q;
   assign dc_wr_ack     = dw_ack_q;
   assign busy          = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run checked against a
// transaction-level reference model of the arbiter.
module tb_mem_arbiter;
   localparam int AW = 26, DW = 32, LW = 4, SL = 16;
   localparam int LINE_BYTES = LW * 4;

   logic clk = 1'b0, rst_n = 1'b0;
   logic ic_rd_req, ic_rd_valid, ic_rd_ack, dc_rd_req, dc_rd_valid, dc_rd_ack;
   logic dc_wr_req, dc_wr_ack, mem_cmd_valid, mem_cmd_ready, mem_cmd_write;
   logic mem_rd_valid, busy;
   logic [AW-1:0] ic_rd_addr, dc_rd_addr, dc_wr_addr, mem_cmd_addr;
   logic [DW-1:0] ic_rd_data, dc_rd_data, dc_wr_data, mem_wr_data, mem_rd_data;

   int checks = 0, errors = 0;

   // reference model: owner -1 idle, 0 I read, 1 D read, 2 D write
   int            m_owner, m_beats_left, m_wait;
   bit            m_cmd_out, m_ack_now, m_write;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .rst_n(rst_n),
      .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_valid(ic_rd_valid),
      .ic_rd_data(ic_rd_data), .ic_rd_ack(ic_rd_ack),
      .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_valid(dc_rd_valid),
      .dc_rd_data(dc_rd_data), .dc_rd_ack(dc_rd_ack),
      .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
      .dc_wr_ack(dc_wr_ack),
      .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
      .mem_cmd_write(mem_cmd_write), .mem_cmd_addr(mem_cmd_addr),
      .mem_wr_data(mem_wr_data), .mem_rd_valid(mem_rd_valid),
      .mem_rd_data(mem_rd_data), .busy(busy));

   always #5 clk = ~clk;

   function automatic logic [AW-1:0] line_base(logic [AW-1:0] a);
      return a - (a % AW'(LINE_BYTES));
   endfunction

   function automatic void model_clear();
      m_owner = -1; m_beats_left = 0; m_wait = 0;
      m_cmd_out = 0; m_ack_now = 0; m_write = 0; m_addr = '0; m_wdata = '0;
   endfunction

   // Advance the model with the inputs the coming edge samples, then clock.
   task automatic step();
      int pick;
      pick = -1;
      if (!rst_n) model_clear();
      else begin
         if (m_ack_now) begin
            m_ack_now = 0; m_owner = -1;
         end else if (m_owner < 0) begin
            if (ic_rd_req && m_wait == SL) pick = 0;
            else if (dc_wr_req)            pick = 2;
            else if (dc_rd_req)            pick = 1;
            else if (ic_rd_req)            pick = 0;
            if (pick >= 0) begin
               m_owner = pick; m_cmd_out = 1; m_write = (pick == 2); m_wdata = dc_wr_data;
               m_addr = (pick == 2) ? dc_wr_addr : line_base(pick == 1 ? dc_rd_addr : ic_rd_addr);
            end
         end else if (m_cmd_out) begin
            if (mem_cmd_ready) begin
               m_cmd_out = 0;
               if (m_write) m_ack_now = 1; else m_beats_left = LW;
            end
         end else if (m_beats_left > 0 && mem_rd_valid) begin
            m_beats_left--;
            if (m_beats_left == 0) m_ack_now = 1;
         end
         if (!ic_rd_req || pick == 0) m_wait = 0;
         else if (m_wait < SL)        m_wait++;
      end
      @(posedge clk); @(negedge clk);
   endtask

   task automatic clear_inputs();
      ic_rd_req = 0; ic_rd_addr = '0; dc_rd_req = 0; dc_rd_addr = '0;
      dc_wr_req = 0; dc_wr_addr = '0; dc_wr_data = '0;
      mem_cmd_ready = 0; mem_rd_valid = 0; mem_rd_data = '0;
   endtask

   task automatic do_reset();
      rst_n = 0; clear_inputs(); model_clear();
      @(posedge clk); @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_reset();
      rst_n = 0; clear_inputs(); model_clear();
      ic_rd_req = 1; dc_wr_req = 1; mem_cmd_ready = 1; mem_rd_valid = 1; mem_rd_data = 'h5A;
      @(posedge clk); @(posedge clk); @(negedge clk); #1;
      checks++; if (mem_cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid got %b want 0", mem_cmd_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (mem_cmd_addr !== '0) begin errors++; $display("FAIL reset_addr got %h want 0", mem_cmd_addr); end
      checks++; if ({mem_cmd_write, mem_wr_data} !== '0) begin errors++; $display("FAIL reset_wr got %b/%h want 0", mem_cmd_write, mem_wr_data); end
      checks++; if ({ic_rd_ack, dc_rd_ack, dc_wr_ack, ic_rd_valid, dc_rd_valid} !== 5'b0) begin
         errors++; $display("FAIL reset_acks_valids got %b want 00000", {ic_rd_ack, dc_rd_ack, dc_wr_ack, ic_rd_valid, dc_rd_valid}); end
      do_reset();
   endtask

   task automatic test_single_ic_read();
      do_reset();
      ic_rd_req = 1; ic_rd_addr = AW'('h123); mem_cmd_ready = 1;
      #1;
      checks++; if (mem_cmd_valid !== 1'b0) begin errors++; $display("FAIL ic_c0_valid got %b want 0", mem_cmd_valid); end
      step(); #1;
      checks++; if (mem_cmd_valid !== 1'b1) begin errors++; $display("FAIL ic_c1_valid got %b want 1", mem_cmd_valid); end
      checks++; if (mem_cmd_addr !== AW'('h120)) begin errors++; $display("FAIL ic_c1_addr got %h want 120", mem_cmd_addr); end
      checks++; if (mem_cmd_write !== 1'b0) begin errors++; $display("FAIL ic_c1_write got %b want 0", mem_cmd_write); end
      step();
      for (int i = 0; i < LW; i++) begin
         mem_rd_valid = 1; mem_rd_data = DW'('hA0 + i); #1;
         checks++; if (ic_rd_valid !== 1'b1 || ic_rd_data !== DW'('hA0 + i)) begin
            errors++; $display("FAIL ic_beat%0d got %b/%h want 1/%h", i, ic_rd_valid, ic_rd_data, DW'('hA0 + i)); end
         checks++; if (dc_rd_valid !== 1'b0 || ic_rd_ack !== 1'b0) begin
            errors++; $display("FAIL ic_beat%0d_side got dcv=%b ack=%b want 0/0", i, dc_rd_valid, ic_rd_ack); end
         step();
      end
      mem_rd_valid = 0; #1;
      checks++; if (ic_rd_ack !== 1'b1) begin errors++; $display("FAIL ic_ack got %b want 1", ic_rd_ack); end
      ic_rd_req = 0;
      step(); #1;
      checks++; if (ic_rd_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ic_after got ack=%b busy=%b want 0/0", ic_rd_ack, busy); end
   endtask

   task automatic test_all_three();
      logic [AW-1:0] ga[$];
      logic          gw[$];
      logic [DW-1:0] gd[$];
      int n_ic = 0, n_dr = 0, n_dw = 0;
      do_reset();
      ic_rd_req = 1; ic_rd_addr = AW'('h300); dc_rd_req = 1; dc_rd_addr = AW'('h208);
      dc_wr_req = 1; dc_wr_addr = AW'('h104); dc_wr_data = 32'h12345678;
      mem_cmd_ready = 1; mem_rd_valid = 1; mem_rd_data = 'h77;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (mem_cmd_valid) begin ga.push_back(mem_cmd_addr); gw.push_back(mem_cmd_write); gd.push_back(mem_wr_data); end
         if (ic_rd_ack) begin n_ic++; ic_rd_req = 0; end
         if (dc_rd_ack) begin n_dr++; dc_rd_req = 0; end
         if (dc_wr_ack) begin n_dw++; dc_wr_req = 0; end
         step();
      end
      checks++; if (ga.size() != 3) begin errors++; $display("FAIL all3_ncmd got %0d want 3", ga.size()); end
      else begin
         checks++; if (gw[0] !== 1'b1 || ga[0] !== AW'('h104) || gd[0] !== 32'h12345678) begin
            errors++; $display("FAIL all3_cmd0 got w=%b a=%h d=%h want 1/104/12345678", gw[0], ga[0], gd[0]); end
         checks++; if (gw[1] !== 1'b0 || ga[1] !== line_base(AW'('h208))) begin
            errors++; $display("FAIL all3_cmd1 got w=%b a=%h want 0/%h", gw[1], ga[1], line_base(AW'('h208))); end
         checks++; if (gw[2] !== 1'b0 || ga[2] !== AW'('h300)) begin
            errors++; $display("FAIL all3_cmd2 got w=%b a=%h want 0/300", gw[2], ga[2]); end
      end
      checks++; if (n_ic != 1 || n_dr != 1 || n_dw != 1) begin
         errors++; $display("FAIL all3_acks got ic=%0d dr=%0d dw=%0d want 1/1/1", n_ic, n_dr, n_dw); end
   endtask

   task automatic test_starvation();
      int idle = 0, occ = 3 + LW + 1, n_exp = 0, ic_cyc = -1, n_dc = 0;
      // first D read is stretched by one backpressure cycle, the rest are minimal
      while (idle < SL) begin idle += occ; occ = 3 + LW; n_exp++; end
      do_reset();
      ic_rd_req = 1; ic_rd_addr = AW'('h404); dc_rd_req = 1; dc_rd_addr = AW'('h808);
      mem_rd_valid = 1; mem_rd_data = 'h11;
      for (int c = 0; c < 60; c++) begin
         mem_cmd_ready = (c != 1); #1;
         if (mem_cmd_valid && mem_cmd_ready && ic_cyc < 0) begin
            if (mem_cmd_addr == AW'('h800)) n_dc++; else ic_cyc = c;
         end
         if (ic_rd_ack) ic_rd_req = 0;
         step();
      end
      checks++; if (n_dc != n_exp) begin errors++; $display("FAIL starve_ndc got %0d want %0d", n_dc, n_exp); end
      checks++; if (ic_cyc != idle + 1) begin errors++; $display("FAIL starve_iccycle got %0d want %0d", ic_cyc, idle + 1); end
   endtask

   task automatic test_backpressure();
      do_reset();
      dc_wr_req = 1; dc_wr_addr = AW'('h40); dc_wr_data = 32'hDEADBEEF;
      step();
      for (int c = 1; c <= 6; c++) begin
         mem_cmd_ready = (c == 6); #1;
         checks++; if (mem_cmd_valid !== 1'b1 || mem_cmd_write !== 1'b1 || mem_cmd_addr !== AW'('h40) || mem_wr_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL bp_hold c=%0d got v=%b w=%b a=%h d=%h want 1/1/40/deadbeef", c, mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_wr_data); end
         checks++; if (dc_wr_ack !== 1'b0) begin errors++; $display("FAIL bp_early_ack c=%0d got %b want 0", c, dc_wr_ack); end
         step();
      end
      mem_cmd_ready = 0; #1;
      checks++; if (dc_wr_ack !== 1'b1 || mem_cmd_valid !== 1'b0) begin
         errors++; $display("FAIL bp_ack got ack=%b v=%b want 1/0", dc_wr_ack, mem_cmd_valid); end
      dc_wr_req = 0;
      step(); #1;
      checks++; if (dc_wr_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_after got ack=%b busy=%b want 0/0", dc_wr_ack, busy); end
   endtask

   task automatic test_stray_beat();
      do_reset();
      mem_rd_valid = 1; mem_rd_data = 'h55;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if ({ic_rd_valid, dc_rd_valid, busy, mem_cmd_valid} !== 4'b0) begin
            errors++; $display("FAIL stray_idle c=%0d got %b want 0000", c, {ic_rd_valid, dc_rd_valid, busy, mem_cmd_valid}); end
         step();
      end
      dc_rd_req = 1; dc_rd_addr = AW'('h0); mem_cmd_ready = 1;
      for (int c = 0; c < 8; c++) begin
         #1;
         checks++; if (dc_rd_ack !== (c == 3 + LW - 1)) begin errors++; $display("FAIL stray_ack c=%0d got %b want %b", c, dc_rd_ack, c == 3 + LW - 1); end
         checks++; if (dc_rd_valid !== (c >= 2 && c < 2 + LW)) begin errors++; $display("FAIL stray_beat c=%0d got %b want %b", c, dc_rd_valid, c >= 2 && c < 2 + LW); end
         if (dc_rd_ack) dc_rd_req = 0;
         step();
      end
   endtask

   task automatic test_reset_mid_burst();
      int beats = 0, acks = 0, ack_c = -1;
      do_reset();
      dc_rd_req = 1; dc_rd_addr = AW'('h1234); mem_cmd_ready = 1;
      step(); step();
      mem_rd_valid = 1; mem_rd_data = 'hB0; step();
      mem_rd_data = 'hB1; step();
      mem_rd_data = 'hB2; #1;
      checks++; if (dc_rd_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b want 1", dc_rd_valid); end
      rst_n = 0; #1;
      checks++; if ({dc_rd_valid, ic_rd_valid, busy, mem_cmd_valid, dc_rd_ack, ic_rd_ack, dc_wr_ack} !== 7'b0 || mem_cmd_addr !== '0) begin
         errors++; $display("FAIL rstmid_outs got %b a=%h want 0", {dc_rd_valid, ic_rd_valid, busy, mem_cmd_valid, dc_rd_ack, ic_rd_ack, dc_wr_ack}, mem_cmd_addr); end
      mem_rd_valid = 0; dc_rd_req = 0;
      step(); rst_n = 1;
      dc_rd_req = 1; dc_rd_addr = AW'('h2000); mem_rd_valid = 1;
      for (int c = 0; c < 12; c++) begin
         mem_rd_data = DW'('hC0 + c); #1;
         if (dc_rd_valid) beats++;
         if (dc_rd_ack) begin acks++; ack_c = c; dc_rd_req = 0; end
         step();
      end
      checks++; if (beats != LW) begin errors++; $display("FAIL rstmid_beats got %0d want %0d", beats, LW); end
      checks++; if (acks != 1 || ack_c != 2 + LW) begin errors++; $display("FAIL rstmid_ack got n=%0d c=%0d want 1/%0d", acks, ack_c, 2 + LW); end
   endtask

   task automatic test_random();
      bit beats;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if (m_ack_now && m_owner == 0) ic_rd_req = 0;
         else if (!ic_rd_req && $urandom_range(3) == 0) begin ic_rd_req = 1; ic_rd_addr = AW'($urandom); end
         if (m_ack_now && m_owner == 1) dc_rd_req = 0;
         else if (!dc_rd_req && $urandom_range(2) == 0) begin dc_rd_req = 1; dc_rd_addr = AW'($urandom); end
         if (m_ack_now && m_owner == 2) dc_wr_req = 0;
         else if (!dc_wr_req && $urandom_range(3) == 0) begin
            dc_wr_req = 1; dc_wr_addr = AW'($urandom) & ~AW'(3); dc_wr_data = $urandom; end
         mem_cmd_ready = ($urandom_range(2) != 0);
         mem_rd_valid  = ($urandom_range(3) != 0);
         mem_rd_data   = $urandom;
         #1;
         checks++; if (mem_cmd_valid !== m_cmd_out) begin errors++; $display("FAIL rnd_valid c=%0d got %b want %b", c, mem_cmd_valid, m_cmd_out); end
         if (m_cmd_out) begin
            checks++; if (mem_cmd_addr !== m_addr || mem_cmd_write !== m_write) begin
               errors++; $display("FAIL rnd_cmd c=%0d got a=%h w=%b want %h/%b", c, mem_cmd_addr, mem_cmd_write, m_addr, m_write); end
            if (m_write) begin
               checks++; if (mem_wr_data !== m_wdata) begin errors++; $display("FAIL rnd_wdata c=%0d got %h want %h", c, mem_wr_data, m_wdata); end
            end
         end
         checks++; if (busy !== (m_owner >= 0)) begin errors++; $display("FAIL rnd_busy c=%0d got %b want %b", c, busy, m_owner >= 0); end
         checks++; if ({ic_rd_ack, dc_rd_ack, dc_wr_ack} !== {m_ack_now && m_owner == 0, m_ack_now && m_owner == 1, m_ack_now && m_owner == 2}) begin
            errors++; $display("FAIL rnd_ack c=%0d got %b owner=%0d ack=%b", c, {ic_rd_ack, dc_rd_ack, dc_wr_ack}, m_owner, m_ack_now); end
         beats = (m_beats_left > 0) && mem_rd_valid;
         checks++; if ({ic_rd_valid, dc_rd_valid} !== {beats && m_owner == 0, beats && m_owner == 1}) begin
            errors++; $display("FAIL rnd_rdvalid c=%0d got %b want %b", c, {ic_rd_valid, dc_rd_valid}, {beats && m_owner == 0, beats && m_owner == 1}); end
         if (beats) begin
            checks++; if ((m_owner == 0 ? ic_rd_data : dc_rd_data) !== mem_rd_data) begin
               errors++; $display("FAIL rnd_rddata c=%0d got %h want %h", c, m_owner == 0 ? ic_rd_data : dc_rd_data, mem_rd_data); end
         end
         step();
      end
   endtask

   initial begin
      clear_inputs(); model_clear();
      @(negedge clk);
      test_reset();
      test_single_ic_read();
      test_all_three();
      test_starvation();
      test_backpressure();
      test_stray_beat();
      test_reset_mid_burst();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
